// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for a MIPS-style Execute stage.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu (ops 7-10) and their accumulate adder.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDU_OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    logic [63:0]        prod_s, prod_u;
    logic [31:0]        a_mag, b_mag, quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;

    // Signed division runs on magnitudes so INT_MIN / -1 never overflows a signed divider.
    always_comb begin
        prod_s = 64'($signed(A)) * 64'($signed(B));
        prod_u = {32'd0, A} * {32'd0, B};
        a_mag  = A[31] ? (32'd0 - A) : A;
        b_mag  = B[31] ? (32'd0 - B) : B;
        quo_u  = 32'd0;
        rem_u  = 32'd0;
        quo_m  = 32'd0;
        rem_m  = 32'd0;
        if (B != 32'd0) begin
            quo_u = A / B;
            rem_u = A % B;
            quo_m = a_mag / b_mag;
            rem_m = a_mag % b_mag;
        end
        quo_s = (A[31] ^ B[31]) ? (32'd0 - quo_m) : quo_m;
        rem_s = A[31] ? (32'd0 - rem_m) : rem_m;
    end

`ifdef MDU_MADD_EN
    logic [63:0] mac_prod, mac_sum;

    always_comb begin
        mac_prod = (MDU_OP == OP_MADD || MDU_OP == OP_MSUB) ? prod_s : prod_u;
        mac_sum  = (MDU_OP == OP_MSUB || MDU_OP == OP_MSUBU) ? ({hi_q, lo_q} - mac_prod)
                                                              : ({hi_q, lo_q} + mac_prod);
    end
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDU_OP)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = (MDU_OP == OP_MULT) ? prod_s : prod_u;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still burns the full latency, then rewrites the old HI/LO.
                            if (B == 32'd0) begin
                                {pend_hi_d, pend_lo_d} = {hi_q, lo_q};
                            end else if (MDU_OP == OP_DIV) begin
                                {pend_hi_d, pend_lo_d} = {rem_s, quo_s};
                            end else begin
                                {pend_hi_d, pend_lo_d} = {rem_u, quo_u};
                            end
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = BUSY;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            {pend_hi_d, pend_lo_d} = mac_sum;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = BUSY;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected HI/LO/latency, a monitor
// checks them when Busy falls. Build with +define+MDU_MADD_EN to exercise madd.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  MDU_OP;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDU_OP (MDU_OP),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drives one start cycle and returns at the following negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        MDU_OP = op;
        A      = a;
        B      = b;
        @(negedge clk);
        start  = 1'b0;
        MDU_OP = 4'd0;
    endtask

    task automatic expect_result(input logic [7:0] tag, input int cyc,
                                 input logic [31:0] hi, input logic [31:0] lo);
        sb.push_back('{tag: tag, cycles: 32'(cyc), hi: hi, lo: lo});
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !Busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    initial begin : monitor
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_cnt = 0;
            end else if (Busy) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got busy_len %0d expected no op at %0t", busy_cnt, $time);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("busy_len#%0d", e.tag), 32'(busy_cnt), e.cycles);
                    check($sformatf("hi#%0d", e.tag), HI, e.hi);
                    check($sformatf("lo#%0d", e.tag), LO, e.lo);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset  = 1'b0;
        start  = 1'b0;
        MDU_OP = 4'd0;
        A      = 32'd0;
        B      = 32'd0;
        #2;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        // Release and issue on the same negedge: first rising edge with reset high takes it.
        @(negedge clk);
        reset = 1'b1;
        expect_result(8'd1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy_up", 32'(Busy), 32'd1);
        check("mult_hold_hi", HI, 32'd0);
        check("mult_hold_lo", LO, 32'd0);
        wait_idle("mult");

        expect_result(8'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_idle("multu");

        expect_result(8'd3, 5, 32'h0000_0000, 32'h0000_0001);
        issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle("mult_neg");

        // div -7/2 with a second div attempted in busy cycle 3, which must be ignored.
        expect_result(8'd4, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        @(negedge clk);
        issue(4'd3, 32'd100, 32'd7);
        check("div_hold_hi", HI, 32'h0000_0000);
        check("div_hold_lo", LO, 32'h0000_0001);
        wait_idle("div");

        expect_result(8'd5, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        issue(4'd3, 32'd7, 32'hFFFF_FFFE);
        wait_idle("div_pos_neg");

        expect_result(8'd6, 10, 32'h0000_0000, 32'h8000_0000);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf");

        expect_result(8'd7, 10, 32'h0000_0005, 32'h1999_9999);
        issue(4'd4, 32'hFFFF_FFFF, 32'd10);
        wait_idle("divu");

        issue(4'd5, 32'h0000_0011, 32'd0);
        issue(4'd6, 32'h0000_0022, 32'd0);
        expect_result(8'd8, 10, 32'h0000_0011, 32'h0000_0022);
        issue(4'd4, 32'd5, 32'd0);
        wait_idle("divu_zero");

        for (int op = 11; op < 16; op++) begin
            issue(4'(op), 32'hDEAD_BEEF, 32'd3);
        end
        issue(4'd0, 32'hDEAD_BEEF, 32'd3);
        check("undef_busy", 32'(Busy), 32'd0);
        check("undef_hi", HI, 32'h0000_0011);
        check("undef_lo", LO, 32'h0000_0022);

        issue(4'd5, 32'h0000_0000, 32'd0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0);
`ifdef MDU_MADD_EN
        expect_result(8'd9, 5, 32'h0000_0001, 32'h0000_0000);
        issue(4'd7, 32'd1, 32'd1);
        wait_idle("madd");
`else
        issue(4'd7, 32'd1, 32'd1);
        check("madd_off_busy", 32'(Busy), 32'd0);
        @(negedge clk);
        check("madd_off_hi", HI, 32'h0000_0000);
        check("madd_off_lo", LO, 32'hFFFF_FFFF);
`endif

        issue(4'd5, 32'h0000_1234, 32'd0);
        check("mthi_hi", HI, 32'h0000_1234);
        check("mthi_busy", 32'(Busy), 32'd0);
        issue(4'd6, 32'h0000_5678, 32'd0);
        check("mtlo_hi", HI, 32'h0000_1234);
        check("mtlo_lo", LO, 32'h0000_5678);
        check("mtlo_busy", 32'(Busy), 32'd0);

        // Reset pulse mid-div: immediate clear, and the aborted result never lands.
        issue(4'd3, 32'd100, 32'd7);
        @(negedge clk);
        check("pre_rst_busy", 32'(Busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(Busy), 32'd0);
        check("mid_rst_hi", HI, 32'd0);
        check("mid_rst_lo", LO, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        check("post_rst_busy", 32'(Busy), 32'd0);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
